// File: rtl/drink_seq_pkg.sv
// Shared types and helpers for the drink ingredient sequencer.
package drink_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  typedef enum logic {
    FIND_FIRST = 1'b0,
    FIND_NEXT  = 1'b1
  } find_mode_t;

  // One-hot of a stage index; callers truncate to their stage count.
  function automatic logic [15:0] stage_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/drink_sequencer_next_stage_finder.sv
// Priority encoder: lowest enabled stage, or lowest enabled stage above cur.
module next_stage_finder
  import drink_seq_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int IDX_W    = $clog2(N_STAGES)
) (
  input  logic [N_STAGES-1:0] mask,
  input  logic [IDX_W-1:0]    cur,
  input  find_mode_t          mode,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  // Scan downwards so the lowest qualifying index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && ((mode == FIND_FIRST) || (i > int'(cur)))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/drink_sequencer.sv
// Ingredient sequencer: walks the enabled valves of a latched recipe mask in
// ascending order, advancing on the level comparator and faulting on timeout.
// Optional build macro DRINK_SEQ_PAUSE_EN adds a pause input that closes the
// valve and freezes the stage timer while held.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start; no valve open
// DISPENSE | valve of stage cur open, waiting for result
// DONE     | recipe complete, waiting for ack
// FAULT    | stage fault_stage timed out, waiting for ack
module drink_sequencer
  import drink_seq_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int TIMER_W  = 8,
  parameter int IDX_W    = $clog2(N_STAGES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N_STAGES-1:0] recipe_mask,
  input  logic                result,
  input  logic [TIMER_W-1:0]  stage_limit,
  input  logic                abort,
  input  logic                ack,
`ifdef DRINK_SEQ_PAUSE_EN
  input  logic                pause,
`endif
  output logic [N_STAGES-1:0] valve,
  output logic [IDX_W-1:0]    stage_idx,
  output logic                busy,
  output logic                finished,
  output logic                fault,
  output logic [IDX_W-1:0]    fault_stage,
  output logic [STATE_W-1:0]  state_output
);

  state_t                state_q, state_d;
  logic [N_STAGES-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;
  logic                  pause_act;

  logic [N_STAGES-1:0]   find_mask;
  find_mode_t            find_mode;
  logic                  find_found;
  logic [IDX_W-1:0]      find_idx;

`ifdef DRINK_SEQ_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  // One finder serves both lookups: first stage of the live mask in IDLE,
  // next stage above cur of the latched mask otherwise.
  assign find_mask = (state_q == S_IDLE) ? recipe_mask : mask_q;
  assign find_mode = (state_q == S_IDLE) ? FIND_FIRST : FIND_NEXT;

  next_stage_finder #(
    .N_STAGES (N_STAGES),
    .IDX_W    (IDX_W)
  ) u_finder (
    .mask  (find_mask),
    .cur   (cur_q),
    .mode  (find_mode),
    .found (find_found),
    .idx   (find_idx)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      cur_q         <= '0;
      timer_q       <= '0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      cur_q         <= cur_d;
      timer_q       <= timer_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  // Next-state: abort beats result, result beats timeout.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cur_d         = cur_q;
    timer_d       = timer_q;
    fault_stage_d = fault_stage_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = recipe_mask;
          timer_d = '0;
          if (find_found) begin
            cur_d   = find_idx;
            state_d = S_DISPENSE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DISPENSE: begin
        if (abort) begin
          cur_d   = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end else if (pause_act) begin
          state_d = S_DISPENSE;
        end else if (result) begin
          timer_d = '0;
          if (find_found) cur_d = find_idx;
          else            state_d = S_DONE;
        end else if ((stage_limit != '0) && (timer_q == stage_limit - TIMER_W'(1))) begin
          fault_stage_d = cur_q;
          state_d       = S_FAULT;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DONE, S_FAULT: begin
        if (ack) begin
          cur_d   = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; pause only gates the valve.
  always_comb begin
    valve        = '0;
    stage_idx    = '0;
    busy         = (state_q == S_DISPENSE);
    finished     = (state_q == S_DONE);
    fault        = (state_q == S_FAULT);
    fault_stage  = (state_q == S_FAULT) ? fault_stage_q : '0;
    state_output = state_q;
    if (state_q == S_DISPENSE) begin
      stage_idx = cur_q;
      if (!pause_act) valve = N_STAGES'(stage_onehot(4'(cur_q)));
    end
  end

endmodule
